// File: rtl/tile_op_pkg.sv
// rtl/tile_op_pkg.sv - shared opcodes, states and CSR bit positions for the tile sequencer
package tile_op_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_DIVQ = 4'd3,
    OP_DIVR = 4'd4
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // command word fields
  localparam int START_BIT = 15;
  localparam int ABORT_BIT = 14;
  localparam int OPC_LSB   = 8;
  localparam int OPC_W     = 4;
  localparam int SAT_BIT   = 1;
  localparam int CHAIN_BIT = 0;

  // status word fields
  localparam int STAT_DONE_BIT    = 0;
  localparam int STAT_DIV0_BIT    = 1;
  localparam int STAT_ILLEGAL_BIT = 2;
  localparam int STAT_OVF_BIT     = 3;
  localparam int STAT_BUSY_BIT    = 4;
  localparam int STAT_ABORT_BIT   = 5;
  localparam int STAT_OPC_LSB     = 6;

  // opcodes that run on the one-bit-per-cycle iterative unit
  function automatic logic op_is_iter(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIVQ) || (op == OP_DIVR);
  endfunction

endpackage

// File: rtl/tile_iter_alu.sv
// rtl/tile_iter_alu.sv - shift-add multiplier and restoring divider, one bit per step
module tile_iter_alu
  import tile_op_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             load,
  input  logic             step,
  input  logic [OPC_W-1:0] op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic [W-1:0]     result,
  output logic             overflow,
  output logic             div0
);

  // hi_q: product high half / partial remainder; lo_q: multiplier / quotient
  logic [W:0]       hi_q, hi_n;
  logic [W-1:0]     lo_q, lo_n;
  logic [W-1:0]     opnd_q;
  logic [OPC_W-1:0] op_q;
  logic             is_mul;
  logic [W:0]       sum;
  logic [W:0]       shifted;

  assign is_mul = (op_q == OP_MUL);

  // one iteration of the selected algorithm applied to the current registers
  always_comb begin
    hi_n    = hi_q;
    lo_n    = lo_q;
    sum     = '0;
    shifted = '0;
    if (is_mul) begin
      sum  = {1'b0, hi_q[W-1:0]} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      hi_n = {1'b0, sum[W:1]};
      lo_n = {sum[0], lo_q[W-1:1]};
    end else begin
      shifted = {hi_q[W-1:0], lo_q[W-1]};
      if (shifted >= {1'b0, opnd_q}) begin
        hi_n = shifted - {1'b0, opnd_q};
        lo_n = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_n = shifted;
        lo_n = {lo_q[W-2:0], 1'b0};
      end
    end
  end

  // outputs show the state after the step in progress, so the final step's
  // result is available in the same cycle the sequencer retires it; a zero
  // divisor naturally yields an all-ones quotient and the dividend as remainder
  always_comb begin
    result   = (op_q == OP_DIVR) ? hi_n[W-1:0] : lo_n;
    overflow = is_mul && (|hi_n[W-1:0]);
    div0     = !is_mul && (opnd_q == '0);
  end

  // operand load on command accept, then one iteration per step
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      op_q   <= '0;
    end else if (load) begin
      hi_q   <= '0;
      lo_q   <= a;
      opnd_q <= b;
      op_q   <= op;
    end else if (step) begin
      hi_q <= hi_n;
      lo_q <= lo_n;
    end
  end

endmodule

// File: rtl/tile_op_sequencer.sv
// rtl/tile_op_sequencer.sv - CSR-driven sequencer for the tile arithmetic datapath
module tile_op_sequencer
  import tile_op_pkg::*;
#(
  parameter int CSR_IN_WIDTH  = 16,
  parameter int CSR_OUT_WIDTH = 16,
  parameter int REG_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [CSR_IN_WIDTH-1:0]  csr_in,
  input  logic [REG_WIDTH-1:0]     data_reg_a,
  input  logic [REG_WIDTH-1:0]     data_reg_b,
  output logic                     csr_in_re,
  output logic [CSR_OUT_WIDTH-1:0] csr_out,
  output logic                     csr_out_we,
  output logic [REG_WIDTH-1:0]     data_reg_c
);

  localparam int CNT_W = $clog2(REG_WIDTH);
  localparam int MSB   = REG_WIDTH - 1;

  state_e                   state_q, state_d;
  logic [OPC_W-1:0]         op_q;
  logic                     sat_q;
  logic [REG_WIDTH-1:0]     a_q, b_q;
  logic [CNT_W-1:0]         cnt_q;

  logic                     start, abort;
  logic [OPC_W-1:0]         cmd_op;
  logic [REG_WIDTH-1:0]     cmd_a;
  logic                     accept, fin, alu_step, legal, iter, update_c;
  logic [REG_WIDTH-1:0]     arith, arith_res, sat_val, res_d, alu_result;
  logic                     arith_ovf, signs_agree, alu_ovf, alu_div0;
  logic [CSR_OUT_WIDTH-1:0] busy_status, fin_status;
  logic                     unused_csr_bits;

  assign start           = csr_in[START_BIT];
  assign abort           = csr_in[ABORT_BIT];
  assign cmd_op          = csr_in[OPC_LSB +: OPC_W];
  assign cmd_a           = csr_in[CHAIN_BIT] ? data_reg_c : data_reg_a;
  assign legal           = (op_q <= OP_DIVR);
  assign iter            = op_is_iter(op_q);
  assign unused_csr_bits = ^{csr_in[13:12], csr_in[7:2]};

  // state register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // next state: abort pre-empts RUN, iterative ops run until the counter expires
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_RUN;
      ST_RUN:   if (abort || !legal || !iter || (cnt_q == '0)) state_d = ST_WRITE;
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // control strobes, ADD/SUB datapath and the two status words
  always_comb begin
    accept   = (state_q == ST_IDLE) && start;
    fin      = (state_q == ST_RUN) && (state_d == ST_WRITE);
    alu_step = (state_q == ST_RUN) && iter;

    arith       = (op_q == OP_SUB) ? (a_q - b_q) : (a_q + b_q);
    signs_agree = (op_q == OP_SUB) ? (a_q[MSB] != b_q[MSB]) : (a_q[MSB] == b_q[MSB]);
    arith_ovf   = signs_agree && (arith[MSB] != a_q[MSB]);
    sat_val     = a_q[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    arith_res   = (sat_q && arith_ovf) ? sat_val : arith;
    res_d       = iter ? alu_result : arith_res;
    update_c    = fin && !abort && legal;

    busy_status                        = '0;
    busy_status[STAT_BUSY_BIT]         = 1'b1;
    busy_status[STAT_OPC_LSB +: OPC_W] = cmd_op;

    fin_status                        = '0;
    fin_status[STAT_OPC_LSB +: OPC_W] = op_q;
    if (abort) begin
      fin_status[STAT_ABORT_BIT] = 1'b1;
    end else if (!legal) begin
      fin_status[STAT_ILLEGAL_BIT] = 1'b1;
    end else begin
      fin_status[STAT_DONE_BIT] = 1'b1;
      fin_status[STAT_DIV0_BIT] = iter && alu_div0;
      fin_status[STAT_OVF_BIT]  = iter ? alu_ovf : arith_ovf;
    end
  end

  // command capture, iteration counter and registered CSR/result outputs
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      op_q       <= '0;
      sat_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cnt_q      <= '0;
      csr_in_re  <= 1'b0;
      csr_out_we <= 1'b0;
      csr_out    <= '0;
      data_reg_c <= '0;
    end else begin
      csr_in_re  <= accept;
      csr_out_we <= accept || fin;
      if (accept) begin
        op_q    <= cmd_op;
        sat_q   <= csr_in[SAT_BIT];
        a_q     <= cmd_a;
        b_q     <= data_reg_b;
        cnt_q   <= CNT_W'(REG_WIDTH - 1);
        csr_out <= busy_status;
      end
      if (alu_step && (cnt_q != '0)) cnt_q <= cnt_q - 1'b1;
      if (fin)      csr_out    <= fin_status;
      if (update_c) data_reg_c <= res_d;
    end
  end

  tile_iter_alu #(.W(REG_WIDTH)) u_iter_alu (
    .clk      (clk),
    .arst_n   (arst_n),
    .load     (accept),
    .step     (alu_step),
    .op       (cmd_op_sel()),
    .a        (cmd_a),
    .b        (data_reg_b),
    .result   (alu_result),
    .overflow (alu_ovf),
    .div0     (alu_div0)
  );

  function automatic logic [OPC_W-1:0] cmd_op_sel();
    return cmd_op;
  endfunction

endmodule

// File: tb/tb_tile_op_sequencer.sv
// tb/tb_tile_op_sequencer.sv - randomized self-checking bench for tile_op_sequencer
module tb_tile_op_sequencer;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [15:0] csr_in = '0;
  logic [31:0] data_reg_a = '0;
  logic [31:0] data_reg_b = '0;
  logic        csr_in_re;
  logic [15:0] csr_out;
  logic        csr_out_we;
  logic [31:0] data_reg_c;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_c = '0;

  tile_op_sequencer dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .csr_in     (csr_in),
    .data_reg_a (data_reg_a),
    .data_reg_b (data_reg_b),
    .csr_in_re  (csr_in_re),
    .csr_out    (csr_out),
    .csr_out_we (csr_out_we),
    .data_reg_c (data_reg_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] cmd_word(input bit start, input bit abort, input int op,
                                           input bit sat, input bit chain);
    logic [3:0] o;
    o = op[3:0];
    return {start, abort, 2'b00, o, 6'b000000, sat, chain};
  endfunction

  // reference: result, final status, whether C is written, and WRITE cycle offset
  task automatic model(input int op, input logic [31:0] a, input logic [31:0] b, input bit sat,
                       output logic [31:0] res, output logic [15:0] st, output bit upd,
                       output int lat);
    longint      sa, sb, s;
    logic [63:0] p;
    bit          ovf;
    st  = 16'(op) << 6;
    res = m_c;
    upd = 1'b1;
    lat = 33;
    case (op)
      0, 1: begin
        lat = 2;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        s   = (op == 0) ? sa + sb : sa - sb;
        ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        p   = 64'(s);
        res = p[31:0];
        if (sat && ovf) res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        st = st | 16'h1 | (ovf ? 16'h8 : 16'h0);
      end
      2: begin
        p   = {32'h0, a} * {32'h0, b};
        res = p[31:0];
        st  = st | 16'h1 | ((p[63:32] != 0) ? 16'h8 : 16'h0);
      end
      3, 4: begin
        if (b == 0) begin
          res = (op == 3) ? 32'hFFFF_FFFF : a;
          st  = st | 16'h3;
        end else begin
          res = (op == 3) ? a / b : a % b;
          st  = st | 16'h1;
        end
      end
      default: begin
        lat = 2;
        upd = 1'b0;
        st  = st | 16'h4;
      end
    endcase
  endtask

  // issue one command; abort_k / ign_k give cycle offsets for abort and a stray start (0 = none)
  task automatic run_cmd(input int op, input logic [31:0] a, input logic [31:0] b, input bit sat,
                         input bit chain, input int abort_k, input int ign_k);
    logic [31:0] res, a_eff;
    logic [15:0] st, busy;
    bit          upd, got;
    int          lat, k;
    a_eff = chain ? m_c : a;
    model(op, a_eff, b, sat, res, st, upd, lat);
    if (abort_k > 1 && abort_k < lat) begin
      lat = abort_k + 1;
      st  = (16'(op) << 6) | 16'h20;
      upd = 1'b0;
    end
    busy = (16'(op) << 6) | 16'h10;

    @(posedge clk); #1;
    csr_in     = cmd_word(1'b1, 1'b0, op, sat, chain);
    data_reg_a = a;
    data_reg_b = b;
    @(negedge clk);
    check("idle_we", csr_out_we, 0);
    check("idle_re", csr_in_re, 0);

    k   = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(posedge clk); #1;
      k++;
      csr_in     = '0;
      data_reg_a = $urandom;
      data_reg_b = $urandom;
      if (k == abort_k) csr_in[14] = 1'b1;
      if (k == ign_k)   csr_in = csr_in | cmd_word(1'b1, 1'b0, 0, 1'b1, 1'b1);
      @(negedge clk);
      if (k == 1) begin
        check("accept_re", csr_in_re, 1);
        check("accept_we", csr_out_we, 1);
        check("busy_status", csr_out, busy);
      end else if (csr_out_we) begin
        got = 1'b1;
      end else begin
        check("hold", {csr_out, data_reg_c}, {busy, m_c});
      end
      if (k == 2) check("re_once", csr_in_re, 0);
    end
    check("latency", k, lat);
    check("status", csr_out, st);
    if (upd) m_c = res;
    check("result", data_reg_c, m_c);
  endtask

  initial begin
    int op, abort_k, ign_k, strobes;
    logic [31:0] a, b;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_c", data_reg_c, 0);
    check("rst_csr", csr_out, 0);
    check("rst_we", csr_out_we, 0);
    check("rst_re", csr_in_re, 0);
    @(posedge clk); #1;
    arst_n = 1'b1;

    // directed scenarios
    run_cmd(0, 32'h7FFF_FFF0, 32'h20, 1'b0, 1'b0, 0, 0);
    run_cmd(0, 32'h7FFF_FFF0, 32'h20, 1'b1, 1'b0, 0, 0);
    run_cmd(1, 32'h8000_0000, 32'h1, 1'b1, 1'b0, 0, 0);
    run_cmd(2, 32'h0001_0000, 32'h0001_0003, 1'b0, 1'b0, 0, 0);
    run_cmd(2, 32'd1234, 32'd5678, 1'b0, 1'b0, 0, 0);
    run_cmd(3, 32'd100, 32'd7, 1'b0, 1'b0, 0, 0);
    run_cmd(4, 32'd100, 32'd7, 1'b0, 1'b0, 0, 0);
    run_cmd(3, 32'd100, 32'd0, 1'b0, 1'b0, 0, 0);
    run_cmd(4, 32'd100, 32'd0, 1'b0, 1'b0, 0, 0);
    run_cmd(9, 32'd5, 32'd6, 1'b0, 1'b0, 0, 0);
    run_cmd(2, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 10, 5);
    run_cmd(3, 32'd100, 32'd7, 1'b0, 1'b0, 0, 20);
    run_cmd(0, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b1, 0, 0);

    // randomized commands
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 5);
      if (op == 5) op = $urandom_range(5, 15);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      abort_k = ($urandom_range(0, 4) == 0) ? $urandom_range(2, 31) : 0;
      ign_k   = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0;
      run_cmd(op, a, b, 1'($urandom), 1'($urandom_range(0, 3) == 0), abort_k, ign_k);
    end

    // reset in the middle of a divide discards it
    @(posedge clk); #1;
    csr_in     = cmd_word(1'b1, 1'b0, 3, 1'b0, 1'b0);
    data_reg_a = 32'd1000;
    data_reg_b = 32'd3;
    @(posedge clk); #1;
    csr_in = '0;
    repeat (10) @(posedge clk);
    #3;
    arst_n = 1'b0;
    #1;
    check("arst_c", data_reg_c, 0);
    check("arst_csr", csr_out, 0);
    check("arst_we", csr_out_we, 0);
    check("arst_re", csr_in_re, 0);
    repeat (2) @(posedge clk);
    #1;
    arst_n  = 1'b1;
    m_c     = '0;
    strobes = 0;
    repeat (40) begin
      @(negedge clk);
      if (csr_out_we) strobes++;
    end
    check("no_strobe_after_rst", strobes, 0);
    run_cmd(0, 32'hFFFF_FFFF, 32'd5, 1'b0, 1'b1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/tile_op_sequencer.md
Name: tile_op_sequencer

Overview:
- User-tile controller: decodes commands written to csr_in, sequences a multi-cycle arithmetic datapath on data_reg_a/data_reg_b, returns the result on data_reg_c, and reports status through csr_out/csr_out_we.
- Connects to the tile side of the CSR/data-register interface: pulse bits are csr_in[15:12], clear-on-read bits are csr_in[3:0] and csr_out[3:0].

Parameters:
- CSR_IN_WIDTH, 16, csr_in width.
- CSR_OUT_WIDTH, 16, csr_out width.
- REG_WIDTH, 32, data register width; also the MUL/DIV iteration count.

Ports:
- clk  in  1  clock.
- arst_n  in  1  asynchronous active-low reset.
- csr_in  in  CSR_IN_WIDTH  command word: [15] start pulse, [14] abort pulse, [13:12] reserved, [11:8] opcode, [1] saturate (clear-on-read), [0] chain (clear-on-read).
- data_reg_a  in  REG_WIDTH  operand A.
- data_reg_b  in  REG_WIDTH  operand B.
- csr_in_re  out  1  one-cycle pulse that consumes csr_in[3:0].
- csr_out  out  CSR_OUT_WIDTH  status: [0] done, [1] div0, [2] illegal, [3] overflow, [4] busy, [5] aborted, [9:6] last opcode, [15:10] zero.
- csr_out_we  out  1  one-cycle status write strobe.
- data_reg_c  out  REG_WIDTH  result register.

Behaviour:
- Reset (async): state IDLE; data_reg_c=0, csr_out=0, csr_out_we=0, csr_in_re=0. Reset mid-operation discards the operation; no status write follows.
- Opcodes: 0 ADD, 1 SUB, 2 MUL (unsigned, low half), 3 DIVQ, 4 DIVR (unsigned restoring divide). 5..15 are illegal.
- States: IDLE, RUN, WRITE.
- IDLE, start=1 in cycle N: at the edge ending N, capture opcode, saturate, chain, B, and A (data_reg_c instead when chain=1); move to RUN.
- Cycle N+1: csr_in_re=1; csr_out_we=1 with csr_out = busy=1, bits[3:0]=0, bit5=0, opcode. A new command discards unread event flags.
- Illegal opcode: RUN lasts one cycle with no datapath activity. WRITE then reports illegal=1, done=0. data_reg_c is unchanged.
- RUN length: ADD/SUB 1 cycle. MUL/DIVQ/DIVR exactly REG_WIDTH cycles (iteration counter counts REG_WIDTH-1 down to 0). No early termination.
- WRITE (one cycle): data_reg_c was updated at the edge entering WRITE. csr_out_we=1 with done=1, busy=0 and flags set; next state IDLE.
- Latency: WRITE occurs in cycle N+2 for ADD/SUB and in cycle N+REG_WIDTH+1 for MUL/DIV.
- ADD/SUB:
  - Arithmetic is signed two's complement, wrapping.
  - overflow = signed overflow.
  - With saturate=1, the result clamps to 0x7FFFFFFF / 0x80000000 (REG_WIDTH generalised).
- MUL: overflow=1 iff the upper REG_WIDTH bits of the 2*REG_WIDTH product are nonzero. The result is always the low half (saturate ignored).
- DIV by zero: completes at full latency, div0=1, done=1. DIVQ result is all ones; DIVR result is the dividend.
- start while not IDLE: ignored; no flag, no strobe.
- abort=1 in RUN: next cycle is WRITE with aborted=1, done=0, other flags 0. data_reg_c is unchanged.
- abort in IDLE or WRITE: ignored.
- start and abort in the same IDLE cycle: start wins and abort is ignored.
- csr_out_we is asserted only in the accept cycle (N+1) and in WRITE. It is never asserted in two consecutive cycles, except that a 1-cycle RUN followed by WRITE gives back-to-back strobes; this is legal.
- A new start is accepted the cycle after WRITE.
- csr_out and data_reg_c are held stable between strobes. csr_out[15:10] is always 0.

Decomposition:
- Package tile_op_pkg:
  - opcode enum (OP_ADD..OP_DIVR), state enum.
  - CSR bit-index localparams: START_BIT=15, ABORT_BIT=14, OPC_LSB=8, CHAIN_BIT=0, SAT_BIT=1, status bit positions.
- Sub-module tile_iter_alu: one-bit-per-cycle shift-add multiplier and restoring divider. Interface: load, step, op, operands in; result and flags out.
- The FSM, CSR decode/encode and the ADD/SUB path stay in tile_op_sequencer.

Test Plan:
- ADD: A=0x7FFFFFF0, B=0x20, saturate=0, start -> WRITE at N+2, data_reg_c=0x80000010, csr_out[3:0]=0b1001, csr_in_re pulses at N+1; repeat with saturate=1 -> 0x7FFFFFFF.
- MUL: A=0x00010000, B=0x00010003 -> WRITE at N+33, data_reg_c=0x00030000, overflow=1. A=1234, B=5678 -> 7006652, overflow=0.
- DIVQ/DIVR: A=100, B=7 -> 14 and 2 at N+33. B=0 -> DIVQ 0xFFFFFFFF and DIVR 100, with div0=1 and done=1.
- Illegal opcode 9 -> WRITE at N+2 with illegal=1, done=0; data_reg_c keeps its prior value.
- Abort: start MUL, abort at N+10 -> aborted=1, done=0 written at N+11; data_reg_c unchanged; a start during RUN is ignored, and a start at N+12 is accepted.
- Chain: result 14, then chain=1 ADD with B=1 -> 15. Assert arst_n low mid-DIV -> all outputs 0 and no strobe after release.
